// File: rtl/mesi_pkg.sv
// Shared encodings for the MESI line controller: line states, bus/snoop
// commands and the controller FSM states.
package mesi_pkg;

  typedef logic [1:0] line_t;
  localparam line_t LS_I = 2'b00;
  localparam line_t LS_S = 2'b01;
  localparam line_t LS_M = 2'b10;
  localparam line_t LS_E = 2'b11;

  typedef logic [1:0] cmd_t;
  localparam cmd_t CMD_NONE = 2'b00;
  localparam cmd_t CMD_RD   = 2'b01;
  localparam cmd_t CMD_WR   = 2'b10;
  localparam cmd_t CMD_INV  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_ACK  = 2'd2
  } ctrl_state_t;

endpackage

// File: rtl/mesi_snoop_next.sv
// Snoop transition for one line: (state, foreign command) -> next state and
// response flags. An I line never responds.
module mesi_snoop_next
  import mesi_pkg::*;
(
  input  line_t state,
  input  cmd_t  cmd,
  output line_t next_state,
  output logic  writeback,
  output logic  shared
);

  always_comb begin
    next_state = state;
    writeback  = 1'b0;
    shared     = 1'b0;
    if (state != LS_I) begin
      case (cmd)
        CMD_RD: begin
          next_state = LS_S;
          writeback  = (state == LS_M);
          shared     = 1'b1;
        end
        CMD_WR: begin
          next_state = LS_I;
          writeback  = (state == LS_M);
        end
        CMD_INV: next_state = LS_I;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/mesi_line_ctrl.sv
// MESI coherence controller for NUM_LINES direct-mapped lines: serves CPU
// accesses, drives bus commands over valid/ready and answers snoops each cycle.
module mesi_line_ctrl
  import mesi_pkg::*;
#(
  parameter int NUM_LINES = 4,
  parameter int IDX_W     = 2
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             cpu_req,
  input  logic             cpu_write,
  input  logic [IDX_W-1:0] cpu_index,
  input  logic             cpu_miss,
  output logic             cpu_ack,
  output logic             bus_valid,
  input  logic             bus_ready,
  output logic [1:0]       bus_cmd,
  output logic             bus_writeback,
  input  logic             bus_shared,
  input  logic             snoop_valid,
  input  logic [1:0]       snoop_cmd,
  input  logic [IDX_W-1:0] snoop_index,
  input  logic             snoop_hit,
  output logic             snoop_writeback,
  output logic             snoop_shared,
  output logic [1:0]       line_state
);

  ctrl_state_t      state, state_nxt;
  line_t            lines    [NUM_LINES];
  line_t            line_nxt [NUM_LINES];
  cmd_t             cmd_q, cmd_nxt, req_cmd;
  logic             wb_q, wb_nxt, req_wb, need_bus;
  logic [IDX_W-1:0] pend_idx;
  logic             snp_wb_q, snp_sh_q;
  line_t            cur_line, hit_next, snp_line, snp_next;
  logic             snp_wb, snp_sh, snoop_eff, conflict, accept, handshake, pend_hit;

  assign cur_line  = lines[cpu_index];
  assign snp_line  = lines[snoop_index];
  assign snoop_eff = snoop_valid & snoop_hit;
  assign conflict  = snoop_eff & (snoop_index == cpu_index);
  assign accept    = (state == ST_IDLE) & cpu_req & ~conflict;
  assign handshake = (state == ST_BUS) & bus_ready;
  assign pend_hit  = (state == ST_BUS) & snoop_eff & (snoop_index == pend_idx);

  mesi_snoop_next u_snoop_next (
    .state      (snp_line),
    .cmd        (snoop_cmd),
    .next_state (snp_next),
    .writeback  (snp_wb),
    .shared     (snp_sh)
  );

  // Classify the CPU access against the current line state.
  always_comb begin
    need_bus = 1'b1;
    req_cmd  = cpu_write ? CMD_WR : CMD_RD;
    req_wb   = 1'b0;
    hit_next = cur_line;
    if (cur_line != LS_I) begin
      if (cpu_miss) begin
        req_wb = (cur_line == LS_M);
      end else if (cpu_write && cur_line == LS_S) begin
        req_cmd = CMD_INV;
      end else begin
        need_bus = 1'b0;
        if (cpu_write && cur_line == LS_E) hit_next = LS_M;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept) state_nxt = need_bus ? ST_BUS : ST_ACK;
      ST_BUS:  if (bus_ready) state_nxt = ST_ACK;
      ST_ACK:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    cpu_ack         = (state == ST_ACK);
    bus_valid       = (state == ST_BUS);
    bus_cmd         = bus_valid ? cmd_q : CMD_NONE;
    bus_writeback   = bus_valid & wb_q;
    snoop_writeback = snp_wb_q;
    snoop_shared    = snp_sh_q;
    line_state      = cur_line;
  end

  // A snoop on the pending line may invalidate it (upgrade becomes a full
  // write miss) or take its dirty data (no write-back left to do).
  always_comb begin
    cmd_nxt = cmd_q;
    wb_nxt  = wb_q;
    if (accept && need_bus) begin
      cmd_nxt = req_cmd;
      wb_nxt  = req_wb;
    end else if (pend_hit) begin
      if (cmd_q == CMD_INV && snp_next == LS_I) cmd_nxt = CMD_WR;
      if (wb_q && snp_wb) wb_nxt = 1'b0;
    end
  end

  // Snoop first, then CPU effects; the handshake result overrides the snoop.
  always_comb begin
    for (int i = 0; i < NUM_LINES; i++) line_nxt[i] = lines[i];
    if (snoop_eff) line_nxt[snoop_index] = snp_next;
    if (accept && !need_bus) line_nxt[cpu_index] = hit_next;
    if (handshake)
      line_nxt[pend_idx] = (cmd_q == CMD_RD) ? (bus_shared ? LS_S : LS_E) : LS_M;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_LINES; i++) lines[i] <= LS_I;
      cmd_q    <= CMD_NONE;
      wb_q     <= 1'b0;
      pend_idx <= '0;
      snp_wb_q <= 1'b0;
      snp_sh_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_LINES; i++) lines[i] <= line_nxt[i];
      cmd_q    <= cmd_nxt;
      wb_q     <= wb_nxt;
      if (accept) pend_idx <= cpu_index;
      snp_wb_q <= snoop_eff & snp_wb;
      snp_sh_q <= snoop_eff & snp_sh;
    end
  end

endmodule

// File: tb/tb_mesi_line_ctrl.sv
// Self-checking bench for mesi_line_ctrl: expected transactions and snoop
// responses are queued when driven and compared when the DUT answers.
module tb_mesi_line_ctrl;

  localparam logic [1:0] I = 2'b00, S = 2'b01, M = 2'b10, E = 2'b11;
  localparam logic [1:0] NONE = 2'b00, RD = 2'b01, WR = 2'b10, INV = 2'b11;

  logic       clock, reset_n;
  logic       cpu_req, cpu_write, cpu_miss, cpu_ack;
  logic [1:0] cpu_index;
  logic       bus_valid, bus_ready, bus_writeback, bus_shared;
  logic [1:0] bus_cmd;
  logic       snoop_valid, snoop_hit, snoop_writeback, snoop_shared;
  logic [1:0] snoop_cmd, snoop_index, line_state;

  typedef struct {
    logic [1:0] cmd;
    logic       wb;
    logic [1:0] st;
  } acc_exp_t;

  typedef struct {
    logic       wb;
    logic       sh;
    logic [1:0] st;
  } snp_exp_t;

  acc_exp_t acc_q[$];
  snp_exp_t snp_q[$];
  int vectors = 0;
  int miscompares = 0;

  mesi_line_ctrl dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .cpu_req         (cpu_req),
    .cpu_write       (cpu_write),
    .cpu_index       (cpu_index),
    .cpu_miss        (cpu_miss),
    .cpu_ack         (cpu_ack),
    .bus_valid       (bus_valid),
    .bus_ready       (bus_ready),
    .bus_cmd         (bus_cmd),
    .bus_writeback   (bus_writeback),
    .bus_shared      (bus_shared),
    .snoop_valid     (snoop_valid),
    .snoop_cmd       (snoop_cmd),
    .snoop_index     (snoop_index),
    .snoop_hit       (snoop_hit),
    .snoop_writeback (snoop_writeback),
    .snoop_shared    (snoop_shared),
    .line_state      (line_state)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // One CPU access; optional snoop on the same line at BUS cycle snp_cyc.
  task automatic run_access(input string name, input bit w, input logic [1:0] idx,
                            input bit miss, input int rdy_dly, input bit shared,
                            input logic [1:0] exp_cmd, input bit exp_wb, input logic [1:0] exp_st,
                            input int snp_cyc, input logic [1:0] snp_c,
                            input logic [1:0] cmd_after, input bit wb_after,
                            input bit exp_swb, input bit exp_ssh);
    acc_exp_t e;
    snp_exp_t s;
    logic [1:0] cur_cmd;
    logic cur_wb;
    int cyc, bus_cyc, hs_cyc, exp_cyc;
    bit done;
    cyc = 0; bus_cyc = 0; hs_cyc = -1; done = 0;
    @(negedge clock);
    e.cmd = exp_cmd; e.wb = exp_wb; e.st = exp_st;
    acc_q.push_back(e);
    cur_cmd = exp_cmd; cur_wb = exp_wb;
    cpu_req = 1; cpu_write = w; cpu_index = idx; cpu_miss = miss;
    while (!done && cyc < 40) begin
      @(negedge clock);
      cyc++;
      if (snp_cyc != 0 && cyc == snp_cyc + 1) begin
        snoop_valid = 0;
        s = snp_q.pop_front();
        vectors++;
        if ({snoop_writeback, snoop_shared} !== {s.wb, s.sh}) begin
          miscompares++;
          $display("FAIL %s snoop_resp: got wb=%b sh=%b expected wb=%b sh=%b",
                   name, snoop_writeback, snoop_shared, s.wb, s.sh);
        end
      end
      if (cpu_ack) begin
        e = acc_q.pop_front();
        vectors++;
        if (line_state !== e.st) begin
          miscompares++;
          $display("FAIL %s line_state: got %b expected %b", name, line_state, e.st);
        end
        exp_cyc = (e.cmd == NONE) ? 1 : hs_cyc + 1;
        vectors++;
        if (cyc !== exp_cyc) begin
          miscompares++;
          $display("FAIL %s ack_latency: got cycle %0d expected cycle %0d", name, cyc, exp_cyc);
        end
        cpu_req = 0; bus_ready = 0; bus_shared = 0;
        done = 1;
      end else if (bus_valid) begin
        vectors++;
        if ({bus_cmd, bus_writeback} !== {cur_cmd, cur_wb}) begin
          miscompares++;
          $display("FAIL %s bus_cmd: got cmd=%b wb=%b expected cmd=%b wb=%b",
                   name, bus_cmd, bus_writeback, cur_cmd, cur_wb);
        end
        if (snp_cyc != 0 && cyc == snp_cyc) begin
          snoop_valid = 1; snoop_hit = 1; snoop_cmd = snp_c; snoop_index = idx;
          s.wb = exp_swb; s.sh = exp_ssh; s.st = I;
          snp_q.push_back(s);
          cur_cmd = cmd_after; cur_wb = wb_after;
        end
        bus_cyc++;
        if (bus_cyc >= rdy_dly && !bus_ready) begin
          bus_ready = 1; bus_shared = shared; hs_cyc = cyc;
        end
      end
    end
    if (!done) begin
      vectors++; miscompares++;
      $display("FAIL %s timeout: got no cpu_ack expected one within 40 cycles", name);
      void'(acc_q.pop_back());
      cpu_req = 0; bus_ready = 0; bus_shared = 0; snoop_valid = 0;
    end
  endtask

  task automatic run_snoop(input string name, input logic [1:0] c, input logic [1:0] idx,
                           input bit exp_wb, input bit exp_sh, input logic [1:0] exp_st);
    snp_exp_t s;
    @(negedge clock);
    snoop_valid = 1; snoop_hit = 1; snoop_cmd = c; snoop_index = idx; cpu_index = idx;
    s.wb = exp_wb; s.sh = exp_sh; s.st = exp_st;
    snp_q.push_back(s);
    @(negedge clock);
    snoop_valid = 0;
    s = snp_q.pop_front();
    vectors++;
    if ({snoop_writeback, snoop_shared, line_state} !== {s.wb, s.sh, s.st}) begin
      miscompares++;
      $display("FAIL %s: got wb=%b sh=%b st=%b expected wb=%b sh=%b st=%b",
               name, snoop_writeback, snoop_shared, line_state, s.wb, s.sh, s.st);
    end
  endtask

  task automatic test_reset();
    reset_n = 0;
    cpu_req = 0; cpu_write = 0; cpu_index = 0; cpu_miss = 0;
    bus_ready = 0; bus_shared = 0;
    snoop_valid = 0; snoop_cmd = 0; snoop_index = 0; snoop_hit = 0;
    repeat (2) @(negedge clock);
    vectors++;
    if ({cpu_ack, bus_valid, bus_cmd, bus_writeback, snoop_writeback, snoop_shared} !== 7'b0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %b expected 0000000",
               {cpu_ack, bus_valid, bus_cmd, bus_writeback, snoop_writeback, snoop_shared});
    end
    for (int i = 0; i < 4; i++) begin
      cpu_index = 2'(i);
      #1;
      vectors++;
      if (line_state !== I) begin
        miscompares++;
        $display("FAIL reset_line%0d: got %b expected %b", i, line_state, I);
      end
    end
    @(negedge clock);
    reset_n = 1;
  endtask

  task automatic test_read_fill();
    run_access("read_fill_l2", 0, 2, 0, 3, 0, RD, 0, E, 0, NONE, NONE, 0, 0, 0);
  endtask

  task automatic test_silent_upgrade();
    run_access("upgrade_l2", 1, 2, 0, 0, 0, NONE, 0, M, 0, NONE, NONE, 0, 0, 0);
  endtask

  task automatic test_snoop();
    run_snoop("snoop_rd_l2_m", RD, 2, 1, 1, S);
    run_snoop("snoop_wr_l0_i", WR, 0, 0, 0, I);
  endtask

  task automatic test_inv_to_write_miss();
    run_access("read_shared_l1", 0, 1, 0, 1, 1, RD, 0, S, 0, NONE, NONE, 0, 0, 0);
    run_access("inv_convert_l1", 1, 1, 0, 3, 0, INV, 0, M, 1, WR, WR, 0, 0, 0);
  endtask

  task automatic test_dirty_victim();
    run_access("write_fill_l3", 1, 3, 0, 1, 0, WR, 0, M, 0, NONE, NONE, 0, 0, 0);
    run_access("read_miss_m_l3", 0, 3, 1, 2, 1, RD, 1, S, 0, NONE, NONE, 0, 0, 0);
  endtask

  task automatic test_hits_and_fixup();
    run_access("read_hit_m_l1", 0, 1, 0, 0, 0, NONE, 0, M, 0, NONE, NONE, 0, 0, 0);
    run_access("write_miss_m_l1", 1, 1, 1, 1, 0, WR, 1, M, 0, NONE, NONE, 0, 0, 0);
    run_access("wb_cleared_l1", 1, 1, 1, 3, 0, WR, 1, M, 1, RD, WR, 0, 1, 1);
  endtask

  task automatic test_conflict();
    @(negedge clock);
    cpu_req = 1; cpu_write = 0; cpu_index = 2; cpu_miss = 0;
    snoop_valid = 1; snoop_hit = 1; snoop_cmd = INV; snoop_index = 2;
    @(negedge clock);
    snoop_valid = 0; cpu_req = 0;
    vectors++;
    if ({cpu_ack, bus_valid, line_state, snoop_writeback, snoop_shared} !== {1'b0, 1'b0, I, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL conflict_l2: got ack=%b valid=%b st=%b wb=%b sh=%b expected 0 0 00 0 0",
               cpu_ack, bus_valid, line_state, snoop_writeback, snoop_shared);
    end
    run_access("retry_l2", 0, 2, 0, 1, 0, RD, 0, E, 0, NONE, NONE, 0, 0, 0);
  endtask

  task automatic test_reset_mid();
    int acks;
    acks = 0;
    @(negedge clock);
    cpu_req = 1; cpu_write = 1; cpu_index = 0; cpu_miss = 0; bus_ready = 0;
    @(negedge clock);
    vectors++;
    if ({bus_valid, bus_cmd} !== {1'b1, WR}) begin
      miscompares++;
      $display("FAIL rst_mid_pending: got valid=%b cmd=%b expected 1 %b", bus_valid, bus_cmd, WR);
    end
    #2 reset_n = 0;
    #1;
    vectors++;
    if ({bus_valid, bus_cmd, cpu_ack} !== 4'b0) begin
      miscompares++;
      $display("FAIL rst_mid_outputs: got valid=%b cmd=%b ack=%b expected 0 00 0",
               bus_valid, bus_cmd, cpu_ack);
    end
    cpu_req = 0;
    for (int i = 0; i < 4; i++) begin
      cpu_index = 2'(i);
      #1;
      vectors++;
      if (line_state !== I) begin
        miscompares++;
        $display("FAIL rst_mid_line%0d: got %b expected %b", i, line_state, I);
      end
    end
    @(negedge clock);
    reset_n = 1;
    repeat (3) begin
      @(negedge clock);
      if (cpu_ack) acks++;
    end
    vectors++;
    if (acks !== 0) begin
      miscompares++;
      $display("FAIL rst_mid_no_ack: got %0d acks expected 0", acks);
    end
    run_access("after_reset_l0", 0, 0, 0, 1, 0, RD, 0, E, 0, NONE, NONE, 0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_read_fill();
    test_silent_upgrade();
    test_snoop();
    test_inv_to_write_miss();
    test_dirty_victim();
    test_hits_and_fixup();
    test_conflict();
    test_reset_mid();
    repeat (2) @(negedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mesi_line_ctrl.md
Name: mesi_line_ctrl

Overview:
- Per-cache MESI coherence controller for a snooping bus, tracking the state of NUM_LINES direct-mapped lines.
- Serves CPU accesses, including silent E->M upgrade and read-miss fill to E or S.
- Issues bus commands over a valid/ready handshake and answers snoops from other caches every cycle.
- Sits between the cache datapath (which supplies tag hit/miss) and the shared coherence bus.

Parameters:
- NUM_LINES, 4, number of tracked lines; must be a power of two, >= 2.
- IDX_W, 2, line index width; must equal log2(NUM_LINES).

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous reset, active low.
- cpu_req  in  1  CPU access valid; held high until cpu_ack.
- cpu_write  in  1  1 = write, 0 = read; stable while cpu_req is high.
- cpu_index  in  IDX_W  line addressed by the CPU.
- cpu_miss  in  1  tag mismatch for cpu_index; ignored when the line is I.
- cpu_ack  out  1  one-cycle pulse: access complete.
- bus_valid  out  1  bus command pending.
- bus_ready  in  1  bus accepts the command; handshake = bus_valid & bus_ready.
- bus_cmd  out  2  00 none, 01 read miss, 10 write miss, 11 invalidate.
- bus_writeback  out  1  dirty victim write-back accompanies bus_cmd.
- bus_shared  in  1  another cache holds the line; sampled at a read-miss handshake.
- snoop_valid  in  1  foreign bus command observed.
- snoop_cmd  in  2  same encoding as bus_cmd.
- snoop_index  in  IDX_W  line addressed by the snoop.
- snoop_hit  in  1  tag match for snoop_index.
- snoop_writeback  out  1  registered pulse: this cache supplies dirty data.
- snoop_shared  out  1  registered pulse: this cache retains a valid copy.
- line_state  out  2  current state of cpu_index (combinational read).

Behaviour:
- Line encoding: I = 00, S = 01, M = 10, E = 11.
- Reset: all lines I; controller in IDLE; all outputs 0; bus_cmd = 00.
- Controller FSM states: IDLE, BUS, ACK.
- IDLE: a CPU request is accepted when cpu_req = 1 and there is no same-cycle snoop conflict (snoop_valid & snoop_hit & snoop_index == cpu_index).
  - Conflicting cycle: not accepted; the CPU holds cpu_req and retries.
- Hit actions (no bus) go straight to ACK with a state update:
  - read hit S/E/M: no change.
  - write hit M: no change.
  - write hit E: E -> M, silent.
- Bus actions register bus_cmd/bus_writeback, raise bus_valid, and go to BUS:
  - read, line I: cmd 01.
  - read miss on S/E: cmd 01.
  - read miss on M: cmd 01, writeback 1.
  - write, line I: cmd 10.
  - write miss on S/E: cmd 10.
  - write miss on M: cmd 10, writeback 1.
  - write hit S: cmd 11.
- BUS: bus_valid, bus_cmd and bus_writeback are held stable until the handshake.
  - At handshake: cmd 01 -> line E if bus_shared = 0, else S; cmd 10/11 -> line M.
  - Then bus_valid = 0 and go to ACK.
- ACK: cpu_ack = 1 for exactly one cycle, then IDLE.
  - Hit latency: cpu_ack is high 1 cycle after acceptance.
  - Miss latency: cpu_ack is high 1 cycle after the handshake.
- Snoop handling: evaluated every cycle in every FSM state; only when snoop_valid & snoop_hit and the line is not I.
  - cmd 01: M -> S with writeback; E -> S; S stays S; shared pulse in all cases.
  - cmd 10: M -> I with writeback; E/S -> I.
  - cmd 11: any -> I, no writeback.
  - cmd 00: ignored.
  - Response pulses appear 1 cycle after the snoop.
- Snoop during BUS on the pending index:
  - A pending invalidate (11) whose line is snooped to I converts to write miss (10) in the next cycle; bus_valid stays high.
  - A pending write-back whose line is snooped M -> S/I (data already supplied) clears bus_writeback.
  - A snoop arriving in the same cycle as the handshake is applied first; the handshake result overrides the line state.
- Asynchronous reset mid-transaction:
  - Immediate return to IDLE with all lines I.
  - bus_valid drops without a handshake.
  - No cpu_ack is issued.

Decomposition:
- Package mesi_pkg holds:
  - line state encodings, bus/snoop command encodings;
  - the FSM state enum.
- One combinational sub-module, mesi_snoop_next: (state, snoop_cmd) -> (next state, writeback, shared). It is shared by the snoop path and the BUS pending-command fixup.

Test Plan:
- Read line 2 from I, bus_shared = 0, bus_ready after 3 cycles -> bus_cmd 01 held 3 cycles; line 2 = E; cpu_ack 1 cycle after handshake.
- Write hit on line 2 in E -> no bus_valid; line 2 = M; cpu_ack 1 cycle after acceptance.
- Snoop read miss on line 2 in M -> snoop_writeback = 1, snoop_shared = 1 next cycle; line 2 = S.
- Write hit line 1 in S, bus_ready low; snoop write miss on line 1 -> bus_cmd 11 changes to 10; at handshake line 1 = M.
- Read miss on line 3 in M -> bus_cmd 01 with bus_writeback 1; bus_shared = 1 -> line 3 = S.
- reset_n low during BUS -> bus_valid 0 immediately; all line_state 00; no cpu_ack; the next request starts from I.
